// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit memory port between the I-cache fetch
// path and the D-cache load/store path. One transaction is outstanding at a
// time. When both sides request together, round-robin picks the winner.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a transaction that has
// waited TIMEOUT cycles for mem_gnt_i. The abort pulses the requester's gnt
// together with err_o. Without the macro, BUSY waits indefinitely and err_o
// is tied low.
//
// Ports
//   clk_i, arst_i                 clock; asynchronous active-high reset
//   icache_req_i/addr_i           I-side fetch request (read, 32-bit result)
//   icache_data_o/gnt_o           I-side read data and completion pulse
//   dcache_req_i/wr_i/addr_i/size_i/data_i
//                                 D-side request
//   dcache_data_o/gnt_o           D-side read data and completion pulse
//   mem_req_o/wr_o/addr_o/size_o/wdata_o
//                                 downstream request, held until mem_gnt_i
//   mem_rdata_i/gnt_i             downstream read data and completion
//   err_o                         timeout abort, coincident with the requester gnt
module mem_port_arbiter #(
    parameter int unsigned AW      = 64,
    parameter int unsigned ICDW    = 32,
    parameter int unsigned DCDW    = 64,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            icache_req_i,
    input  logic [AW-1:0]   icache_addr_i,
    output logic [ICDW-1:0] icache_data_o,
    output logic            icache_gnt_o,
    input  logic            dcache_req_i,
    input  logic            dcache_wr_i,
    input  logic [AW-1:0]   dcache_addr_i,
    input  logic [1:0]      dcache_size_i,
    input  logic [DCDW-1:0] dcache_data_i,
    output logic [DCDW-1:0] dcache_data_o,
    output logic            dcache_gnt_o,
    output logic            mem_req_o,
    output logic            mem_wr_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [1:0]      mem_size_o,
    output logic [DCDW-1:0] mem_wdata_o,
    input  logic [DCDW-1:0] mem_rdata_i,
    input  logic            mem_gnt_i,
    output logic            err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;   // 1: D side was served last
    logic              sel_hi_q, sel_hi_d;   // saved fetch addr[2]: upper word
    logic              mem_wr_d;
    logic [AW-1:0]     mem_addr_d;
    logic [1:0]        mem_size_d;
    logic [DCDW-1:0]   mem_wdata_d;
    logic              timeout_c;
    logic              done_c;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;

    // Wait counter: cleared in IDLE, so each BUSY entry starts from zero.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (!mem_gnt_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // A grant arriving in the final cycle takes precedence over the abort.
    assign timeout_c = (state_q != IDLE) && !mem_gnt_i && (cnt_q == CW'(TIMEOUT - 1));
`else
    logic [31:0] unused_timeout_c;
    assign unused_timeout_c = 32'(TIMEOUT);
    assign timeout_c        = 1'b0;
`endif

    assign done_c = mem_gnt_i || timeout_c;

    // State and request registers.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            sel_hi_q    <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_wr_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_size_o  <= 2'd0;
            mem_wdata_o <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            sel_hi_q    <= sel_hi_d;
            mem_req_o   <= (state_d != IDLE);
            mem_wr_o    <= mem_wr_d;
            mem_addr_o  <= mem_addr_d;
            mem_size_o  <= mem_size_d;
            mem_wdata_o <= mem_wdata_d;
        end
    end

    // Next state, arbitration and completion outputs.
    always_comb begin
        state_d       = state_q;
        last_d_d      = last_d_q;
        sel_hi_d      = sel_hi_q;
        mem_wr_d      = mem_wr_o;
        mem_addr_d    = mem_addr_o;
        mem_size_d    = mem_size_o;
        mem_wdata_d   = mem_wdata_o;
        icache_gnt_o  = 1'b0;
        dcache_gnt_o  = 1'b0;
        err_o         = 1'b0;
        icache_data_o = sel_hi_q ? mem_rdata_i[2*ICDW-1:ICDW] : mem_rdata_i[ICDW-1:0];
        dcache_data_o = mem_rdata_i;

        if (timeout_c) begin
            icache_data_o = '0;
            dcache_data_o = '0;
        end

        case (state_q)
            IDLE: begin
                // I wins a tie unless it was served last.
                if (icache_req_i && (!dcache_req_i || last_d_q)) begin
                    state_d     = BUSY_I;
                    mem_wr_d    = 1'b0;
                    mem_size_d  = 2'd2;
                    mem_addr_d  = icache_addr_i;
                    mem_wdata_d = '0;
                    sel_hi_d    = icache_addr_i[2];
                end else if (dcache_req_i) begin
                    state_d     = BUSY_D;
                    mem_wr_d    = dcache_wr_i;
                    mem_size_d  = dcache_size_i;
                    mem_addr_d  = dcache_addr_i;
                    mem_wdata_d = dcache_data_i;
                end
            end
            BUSY_I: begin
                if (done_c) begin
                    icache_gnt_o = 1'b1;
                    err_o        = timeout_c;
                    state_d      = IDLE;
                    last_d_d     = 1'b0;
                end
            end
            BUSY_D: begin
                if (done_c) begin
                    dcache_gnt_o = 1'b1;
                    err_o        = timeout_c;
                    state_d      = IDLE;
                    last_d_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: expected completions are queued
// when requests are raised and popped as gnt pulses appear.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 64;
    localparam int unsigned ICDW = 32;
    localparam int unsigned DCDW = 64;
    localparam int unsigned TO   = 4;

    logic            clk_i = 1'b0;
    logic            arst_i;
    logic            icache_req_i;
    logic [AW-1:0]   icache_addr_i;
    logic [ICDW-1:0] icache_data_o;
    logic            icache_gnt_o;
    logic            dcache_req_i;
    logic            dcache_wr_i;
    logic [AW-1:0]   dcache_addr_i;
    logic [1:0]      dcache_size_i;
    logic [DCDW-1:0] dcache_data_i;
    logic [DCDW-1:0] dcache_data_o;
    logic            dcache_gnt_o;
    logic            mem_req_o;
    logic            mem_wr_o;
    logic [AW-1:0]   mem_addr_o;
    logic [1:0]      mem_size_o;
    logic [DCDW-1:0] mem_wdata_o;
    logic [DCDW-1:0] mem_rdata_i;
    logic            mem_gnt_i;
    logic            err_o;

    mem_port_arbiter #(
        .AW(AW), .ICDW(ICDW), .DCDW(DCDW), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .icache_req_i(icache_req_i), .icache_addr_i(icache_addr_i),
        .icache_data_o(icache_data_o), .icache_gnt_o(icache_gnt_o),
        .dcache_req_i(dcache_req_i), .dcache_wr_i(dcache_wr_i),
        .dcache_addr_i(dcache_addr_i), .dcache_size_i(dcache_size_i),
        .dcache_data_i(dcache_data_i), .dcache_data_o(dcache_data_o),
        .dcache_gnt_o(dcache_gnt_o),
        .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_size_o(mem_size_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_gnt_i(mem_gnt_i), .err_o(err_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        side_d;
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   gnt_cyc[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   mem_wait = 0;
    int   wcnt = 0;
    bit   mem_en = 1'b0;
    bit   idle_pulse = 1'b0;
    int   i_left = 0;
    int   d_left = 0;
    int   i_gnt_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic side_d, input logic err, input logic [63:0] data);
        exp_t e;
        e.side_d = side_d;
        e.err    = err;
        e.data   = data;
        sb.push_back(e);
    endtask

    // One clock: memory responder drives at +1, outputs are sampled at +2.
    task automatic step();
        exp_t e;
        @(posedge clk_i);
        #1;
        cyc++;
        if (mem_gnt_i) begin
            mem_gnt_i = 1'b0;
            wcnt      = 0;
        end else if (idle_pulse) begin
            mem_gnt_i  = 1'b1;
            idle_pulse = 1'b0;
        end else if (mem_en && mem_req_o) begin
            if (wcnt >= mem_wait) mem_gnt_i = 1'b1;
            else wcnt++;
        end else begin
            wcnt = 0;
        end
        #1;
        if (icache_gnt_o || dcache_gnt_o) begin
            gnt_cyc.push_back(cyc);
            if (icache_gnt_o) i_gnt_cnt++;
            if (sb.size() == 0) begin
                check("gnt_unexpected", {62'd0, icache_gnt_o, dcache_gnt_o}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("gnt_side", {62'd0, icache_gnt_o, dcache_gnt_o}, e.side_d ? 64'd1 : 64'd2);
                check("gnt_data", e.side_d ? dcache_data_o : {32'd0, icache_data_o}, e.data);
                check("gnt_err", {63'd0, err_o}, {63'd0, e.err});
            end
            if (icache_gnt_o && i_left > 0) begin
                i_left--;
                if (i_left == 0) icache_req_i = 1'b0;
            end
            if (dcache_gnt_o && d_left > 0) begin
                d_left--;
                if (d_left == 0) dcache_req_i = 1'b0;
            end
        end
    endtask

    task automatic wait_req(input string tag, output int n);
        n = 0;
        while (!mem_req_o && n < 10) begin
            step();
            n++;
        end
        check({tag, "_req_seen"}, {63'd0, mem_req_o}, 64'd1);
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n = 0;
        while ((sb.size() != 0 || mem_req_o) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done"}, {63'd0, (sb.size() == 0 && !mem_req_o)}, 64'd1);
    endtask

    initial begin
        int n;
        int t0;
        int g0;
        arst_i        = 1'b1;
        icache_req_i  = 1'b0;
        icache_addr_i = '0;
        dcache_req_i  = 1'b0;
        dcache_wr_i   = 1'b0;
        dcache_addr_i = '0;
        dcache_size_i = 2'd0;
        dcache_data_i = '0;
        mem_rdata_i   = '0;
        mem_gnt_i     = 1'b0;
        step();
        step();

        // Reset values
        check("rst_req",   {63'd0, mem_req_o}, 64'd0);
        check("rst_wr",    {63'd0, mem_wr_o}, 64'd0);
        check("rst_addr",  mem_addr_o, 64'd0);
        check("rst_size",  {62'd0, mem_size_o}, 64'd0);
        check("rst_wdata", mem_wdata_o, 64'd0);
        check("rst_gnt",   {61'd0, icache_gnt_o, dcache_gnt_o, err_o}, 64'd0);
        arst_i = 1'b0;
        step();

        // Grant from memory while idle is ignored
        idle_pulse = 1'b1;
        step();
        check("idle_pulse_gnt", {61'd0, icache_gnt_o, dcache_gnt_o, err_o}, 64'd0);
        step();
        check("idle_pulse_req", {63'd0, mem_req_o}, 64'd0);

        // Single I fetch, upper word, three wait cycles
        mem_rdata_i   = 64'hAAAA_BBBB_CCCC_DDDD;
        mem_en        = 1'b1;
        mem_wait      = 3;
        icache_addr_i = 64'h1004;
        i_left        = 1;
        g0            = i_gnt_cnt;
        push_exp(1'b0, 1'b0, 64'h0000_0000_AAAA_BBBB);
        icache_req_i  = 1'b1;
        wait_req("ifetch", n);
        check("ifetch_latency", 64'(n), 64'd1);
        check("ifetch_size", {62'd0, mem_size_o}, 64'd2);
        check("ifetch_wr",   {63'd0, mem_wr_o}, 64'd0);
        check("ifetch_addr", mem_addr_o, 64'h1004);
        run_until_done("ifetch", 20);
        check("ifetch_gnt_pulses", 64'(i_gnt_cnt - g0), 64'd1);

        // Reset during BUSY_D, then a tie goes to I
        mem_en        = 1'b0;
        dcache_wr_i   = 1'b0;
        dcache_addr_i = 64'h4000;
        dcache_size_i = 2'd3;
        dcache_req_i  = 1'b1;
        wait_req("rstmid", n);
        arst_i = 1'b1;
        #1;
        check("rstmid_req", {63'd0, mem_req_o}, 64'd0);
        check("rstmid_gnt", {62'd0, icache_gnt_o, dcache_gnt_o}, 64'd0);
        icache_addr_i = 64'h1000;
        icache_req_i  = 1'b1;
        i_left        = 1;
        d_left        = 1;
        push_exp(1'b0, 1'b0, 64'h0000_0000_CCCC_DDDD);
        push_exp(1'b1, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);
        mem_en   = 1'b1;
        mem_wait = 0;
        wcnt     = 0;
        step();
        arst_i = 1'b0;
        run_until_done("rstmid", 30);

        // D write: fields registered on entry and held until gnt
        mem_rdata_i   = 64'h0F1E_2D3C_4B5A_6978;
        mem_wait      = 2;
        dcache_wr_i   = 1'b1;
        dcache_addr_i = 64'h2000;
        dcache_size_i = 2'd3;
        dcache_data_i = 64'h1122_3344_5566_7788;
        d_left        = 1;
        push_exp(1'b1, 1'b0, 64'h0F1E_2D3C_4B5A_6978);
        dcache_req_i  = 1'b1;
        wait_req("dwr", n);
        dcache_wr_i   = 1'b0;
        dcache_addr_i = 64'hFFFF;
        dcache_size_i = 2'd0;
        dcache_data_i = '0;
        for (int k = 0; k < 10 && mem_req_o; k++) begin
            check("dwr_wr",    {63'd0, mem_wr_o}, 64'd1);
            check("dwr_addr",  mem_addr_o, 64'h2000);
            check("dwr_size",  {62'd0, mem_size_o}, 64'd3);
            check("dwr_wdata", mem_wdata_o, 64'h1122_3344_5566_7788);
            step();
        end
        run_until_done("dwr", 10);

        // Both requesters held for four zero-wait transactions
        mem_rdata_i   = 64'hDEAD_BEEF_0123_4567;
        mem_wait      = 0;
        icache_addr_i = 64'h3000;
        dcache_wr_i   = 1'b0;
        dcache_addr_i = 64'h3008;
        dcache_size_i = 2'd3;
        i_left        = 2;
        d_left        = 2;
        push_exp(1'b0, 1'b0, 64'h0000_0000_0123_4567);
        push_exp(1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567);
        push_exp(1'b0, 1'b0, 64'h0000_0000_0123_4567);
        push_exp(1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567);
        gnt_cyc.delete();
        icache_req_i = 1'b1;
        dcache_req_i = 1'b1;
        run_until_done("rr", 30);
        check("rr_count", 64'(gnt_cyc.size()), 64'd4);
        for (int i = 1; i < gnt_cyc.size(); i++)
            check("rr_spacing", 64'(gnt_cyc[i] - gnt_cyc[i-1]), 64'd2);

`ifdef MEM_ARB_TIMEOUT_EN
        // No grant: abort on the fourth BUSY cycle with err_o and zero data
        mem_en        = 1'b0;
        dcache_addr_i = 64'h5000;
        d_left        = 1;
        push_exp(1'b1, 1'b1, 64'd0);
        gnt_cyc.delete();
        dcache_req_i  = 1'b1;
        wait_req("to", n);
        t0 = cyc;
        run_until_done("to", 20);
        check("to_count", 64'(gnt_cyc.size()), 64'd1);
        if (gnt_cyc.size() > 0) check("to_cycle", 64'(gnt_cyc[0] - t0 + 1), 64'd4);

        // Grant in the same cycle as the timeout wins
        mem_en   = 1'b1;
        mem_wait = 3;
        wcnt     = 0;
        d_left   = 1;
        push_exp(1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567);
        gnt_cyc.delete();
        dcache_req_i = 1'b1;
        wait_req("to_race", n);
        t0 = cyc;
        run_until_done("to_race", 20);
        check("to_race_count", 64'(gnt_cyc.size()), 64'd1);
        if (gnt_cyc.size() > 0) check("to_race_cycle", 64'(gnt_cyc[0] - t0 + 1), 64'd4);
`else
        // No timeout: request stays pending indefinitely
        mem_en        = 1'b0;
        dcache_addr_i = 64'h5000;
        dcache_req_i  = 1'b1;
        wait_req("hold", n);
        repeat (20) step();
        check("hold_req", {63'd0, mem_req_o}, 64'd1);
        check("hold_err", {63'd0, err_o}, 64'd0);
        dcache_req_i = 1'b0;
        arst_i = 1'b1;
        step();
        arst_i = 1'b0;
        step();
        check("hold_reset_req", {63'd0, mem_req_o}, 64'd0);
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
